sys_cmd_master: RTL and testbench

- Host-side command initiator for the system controller's UART command protocol. Sits in front of a UART transmitter and behind a UART receiver (byte-level, same clock domain).
- Accepts one command at a time over a valid/ready handshake and serialises it into command frame bytes. Then collects the response bytes and returns them as a 16-bit result, or flags a timeout.

---
 rtl/sys_cmd_master_if.sv | 50 +++++
 rtl/sys_cmd_master.sv | 213 +++++++++++++++++++++
 tb/tb_sys_cmd_master.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_master_if.sv
// sys_cmd_master_if: command, UART byte and response bundle
// master side is the command initiator, slave side its environment
interface sys_cmd_master_if;

   // command request
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_TYPE;
   logic [7:0] CMD_ADDR;
   logic [7:0] CMD_DATA;
   logic [7:0] CMD_OP_A;
   logic [7:0] CMD_OP_B;
   logic [3:0] CMD_FUN;

   // frame bytes to the UART transmitter
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;

   // response bytes from the UART receiver
   logic [7:0] RX_DATA;
   logic       RX_VALID;

   // result
   logic [15:0] RSP_DATA;
   logic        RSP_VALID;
   logic        RSP_TIMEOUT;
   logic        BUSY;

   modport master (
      input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_DATA,
      input  CMD_OP_A, CMD_OP_B, CMD_FUN,
      output CMD_READY,
      output TX_DATA, TX_VALID,
      input  TX_READY,
      input  RX_DATA, RX_VALID,
      output RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
   );

   modport slave (
      output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_DATA,
      output CMD_OP_A, CMD_OP_B, CMD_FUN,
      input  CMD_READY,
      input  TX_DATA, TX_VALID,
      output TX_READY,
      output RX_DATA, RX_VALID,
      input  RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
   );

endinterface

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serialises one command into a UART frame and collects the response.
// Define SYS_CMD_TIMEOUT_EN to build the inter-byte response timeout.
module sys_cmd_master #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   sys_cmd_master_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_RSP,
      S_DONE
   } state_t;

   localparam logic [1:0] T_WR  = 2'b00;
   localparam logic [1:0] T_RD  = 2'b01;
   localparam logic [1:0] T_ALU = 2'b10;

   state_t      state_q;

   // latched command
   logic [1:0]  type_q;
   logic [7:0]  addr_q;
   logic [7:0]  data_q;
   logic [7:0]  opa_q;
   logic [7:0]  opb_q;
   logic [3:0]  fun_q;

   // frame and response progress
   logic [1:0]  idx_q;
   logic        rx_cnt_q;
   logic [7:0]  lo_q;

   // registered outputs
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic [15:0] rsp_data_q;
   logic        rsp_valid_q;

`ifdef SYS_CMD_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_to_q;
`endif

   // frame decode for the byte following the current one
   logic [1:0]  nidx;
   logic [1:0]  last_idx;
   logic [7:0]  next_byte;

   function automatic logic [7:0] hdr(input logic [1:0] t);
      logic [7:0] h;
      unique case (t)
         2'b00:   h = 8'hAA;
         2'b01:   h = 8'hBB;
         2'b10:   h = 8'hCC;
         default: h = 8'hDD;
      endcase
      return h;
   endfunction

   // pick the frame length and the next payload byte from the latched command
   always_comb begin
      nidx      = idx_q + 2'd1;
      last_idx  = 2'd1;
      next_byte = 8'h00;
      unique case (type_q)
         2'b00: begin
            last_idx  = 2'd2;
            next_byte = (nidx == 2'd1) ? addr_q : data_q;
         end
         2'b01: begin
            last_idx  = 2'd1;
            next_byte = addr_q;
         end
         2'b10: begin
            last_idx  = 2'd3;
            if (nidx == 2'd1)
               next_byte = opa_q;
            else if (nidx == 2'd2)
               next_byte = opb_q;
            else
               next_byte = {4'h0, fun_q};
         end
         default: begin
            last_idx  = 2'd1;
            next_byte = {4'h0, fun_q};
         end
      endcase
   end

   // command FSM: accept, send frame, collect response, report
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         type_q      <= 2'b00;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         opa_q       <= 8'h00;
         opb_q       <= 8'h00;
         fun_q       <= 4'h0;
         idx_q       <= 2'd0;
         rx_cnt_q    <= 1'b0;
         lo_q        <= 8'h00;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_valid_q <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_to_q    <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
         rsp_to_q    <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (bus.CMD_VALID) begin
                  type_q     <= bus.CMD_TYPE;
                  addr_q     <= bus.CMD_ADDR;
                  data_q     <= bus.CMD_DATA;
                  opa_q      <= bus.CMD_OP_A;
                  opb_q      <= bus.CMD_OP_B;
                  fun_q      <= bus.CMD_FUN;
                  idx_q      <= 2'd0;
                  tx_data_q  <= hdr(bus.CMD_TYPE);
                  tx_valid_q <= 1'b1;
                  state_q    <= S_SEND;
               end
            end

            S_SEND: begin
               if (tx_valid_q && bus.TX_READY) begin
                  if (idx_q == last_idx) begin
                     tx_valid_q <= 1'b0;
                     rx_cnt_q   <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
                     cnt_q      <= '0;
`endif
                     if (type_q == T_WR) begin
                        rsp_data_q <= 16'h0000;
                        state_q    <= S_DONE;
                     end else begin
                        state_q    <= S_WAIT_RSP;
                     end
                  end else begin
                     idx_q     <= nidx;
                     tx_data_q <= next_byte;
                  end
               end
            end

            S_WAIT_RSP: begin
               if (bus.RX_VALID) begin
`ifdef SYS_CMD_TIMEOUT_EN
                  cnt_q <= '0;
`endif
                  if (type_q == T_RD) begin
                     rsp_data_q <= {8'h00, bus.RX_DATA};
                     state_q    <= S_DONE;
                  end else if (!rx_cnt_q) begin
                     lo_q     <= bus.RX_DATA;
                     rx_cnt_q <= 1'b1;
                  end else begin
                     rsp_data_q <= {bus.RX_DATA, lo_q};
                     rx_cnt_q   <= 1'b0;
                     state_q    <= S_DONE;
                  end
               end
`ifdef SYS_CMD_TIMEOUT_EN
               else if (cnt_q == TO_LAST) begin
                  rsp_to_q <= 1'b1;
                  rx_cnt_q <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end

            S_DONE: begin
               rsp_valid_q <= 1'b1;
               state_q     <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.CMD_READY = (state_q == S_IDLE);
   assign bus.BUSY      = (state_q != S_IDLE);
   assign bus.TX_DATA   = tx_data_q;
   assign bus.TX_VALID  = tx_valid_q;
   assign bus.RSP_DATA  = rsp_data_q;
   assign bus.RSP_VALID = rsp_valid_q;
`ifdef SYS_CMD_TIMEOUT_EN
   assign bus.RSP_TIMEOUT = rsp_to_q;
`else
   assign bus.RSP_TIMEOUT = 1'b0;
`endif

   // ALU type constant kept for readability of the decode above
   logic unused_alu;
   assign unused_alu = (type_q == T_ALU);

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: directed bench for the UART command initiator.
// Timeout checks depend on SYS_CMD_TIMEOUT_EN, matching the RTL build.
module tb_sys_cmd_master;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   sys_cmd_master_if bus();

   sys_cmd_master #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout req finish");
      $fatal(1);
   end

   task automatic issue(input logic [1:0] t, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] oa,
                        input logic [7:0] ob, input logic [3:0] f);
      bus.CMD_VALID = 1'b1;
      bus.CMD_TYPE  = t;
      bus.CMD_ADDR  = a;
      bus.CMD_DATA  = d;
      bus.CMD_OP_A  = oa;
      bus.CMD_OP_B  = ob;
      bus.CMD_FUN   = f;
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
   endtask

   // drives TX_READY and records accepted bytes; held=0 if a stalled byte moved
   task automatic run_frame(input int n, input bit toggle,
                            output logic [7:0] got [4], output int cyc,
                            output bit held);
      logic [7:0] prev;
      bit stalled;
      int i;
      i = 0;
      cyc = 0;
      held = 1'b1;
      stalled = 1'b0;
      prev = 8'h00;
      got = '{default: 8'h00};
      while (i < n && cyc < 32) begin
         if (stalled && (bus.TX_DATA !== prev || bus.TX_VALID !== 1'b1))
            held = 1'b0;
         bus.TX_READY = toggle ? ((cyc % 2) == 0) : 1'b1;
         if (bus.TX_READY && bus.TX_VALID === 1'b1) begin
            got[i] = bus.TX_DATA;
            i++;
            stalled = 1'b0;
         end else begin
            prev = bus.TX_DATA;
            stalled = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      bus.TX_READY = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({bus.CMD_READY, bus.BUSY, bus.TX_VALID, bus.RSP_VALID,
           bus.RSP_TIMEOUT} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_flags got %b%b%b%b%b req 10000", bus.CMD_READY,
                  bus.BUSY, bus.TX_VALID, bus.RSP_VALID, bus.RSP_TIMEOUT);
      end
      tests++;
      if (bus.TX_DATA !== 8'h00 || bus.RSP_DATA !== 16'h0000) begin
         fails++;
         $display("FAIL reset_data got tx=%h rsp=%h req 00/0000",
                  bus.TX_DATA, bus.RSP_DATA);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read;
      logic [7:0] exp [4];
      logic [7:0] got [4];
      int cyc;
      bit held;
      exp = '{8'hBB, 8'h05, 8'h00, 8'h00};
      issue(2'b01, 8'h05, 8'h00, 8'h00, 8'h00, 4'h0);
      run_frame(2, 1'b0, got, cyc, held);
      for (int j = 0; j < 2; j++) begin
         tests++;
         if (got[j] !== exp[j]) begin
            fails++;
            $display("FAIL read_tx[%0d] got %h req %h", j, got[j], exp[j]);
         end
      end
      tests++;
      if (cyc !== 2 || bus.TX_VALID !== 1'b0 || bus.BUSY !== 1'b1) begin
         fails++;
         $display("FAIL read_send_end got cyc=%0d v=%b busy=%b req 2/0/1",
                  cyc, bus.TX_VALID, bus.BUSY);
      end
      repeat (3) @(negedge clk);
      bus.RX_DATA  = 8'h3C;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      tests++;
      if (bus.RSP_VALID !== 1'b0) begin
         fails++;
         $display("FAIL read_early got rsp_valid=%b req 0", bus.RSP_VALID);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h003C) begin
         fails++;
         $display("FAIL read_rsp got v=%b d=%h req 1/003c",
                  bus.RSP_VALID, bus.RSP_DATA);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1) begin
         fails++;
         $display("FAIL read_after got v=%b rdy=%b req 0/1",
                  bus.RSP_VALID, bus.CMD_READY);
      end
   endtask

   task automatic test_write;
      logic [7:0] exp [4];
      logic [7:0] got [4];
      int cyc;
      bit held;
      exp = '{8'hAA, 8'h02, 8'h81, 8'h00};
      issue(2'b00, 8'h02, 8'h81, 8'h00, 8'h00, 4'h0);
      run_frame(3, 1'b0, got, cyc, held);
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (got[j] !== exp[j]) begin
            fails++;
            $display("FAIL write_tx[%0d] got %h req %h", j, got[j], exp[j]);
         end
      end
      tests++;
      if (cyc !== 3 || bus.TX_VALID !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
         fails++;
         $display("FAIL write_send_end got cyc=%0d v=%b rv=%b req 3/0/0",
                  cyc, bus.TX_VALID, bus.RSP_VALID);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h0000) begin
         fails++;
         $display("FAIL write_rsp got v=%b d=%h req 1/0000",
                  bus.RSP_VALID, bus.RSP_DATA);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b0) begin
         fails++;
         $display("FAIL write_pulse got v=%b req 0", bus.RSP_VALID);
      end
   endtask

   task automatic test_alu;
      logic [7:0] exp [4];
      logic [7:0] got [4];
      int cyc;
      bit held;
      exp = '{8'hCC, 8'h12, 8'h34, 8'h01};
      bus.RX_DATA  = 8'hEE;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      issue(2'b10, 8'h00, 8'h00, 8'h12, 8'h34, 4'h1);
      run_frame(4, 1'b1, got, cyc, held);
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (got[j] !== exp[j]) begin
            fails++;
            $display("FAIL alu_tx[%0d] got %h req %h", j, got[j], exp[j]);
         end
      end
      tests++;
      if (cyc !== 7 || held !== 1'b1 || bus.TX_VALID !== 1'b0) begin
         fails++;
         $display("FAIL alu_stall got cyc=%0d held=%b v=%b req 7/1/0",
                  cyc, held, bus.TX_VALID);
      end
      bus.RX_DATA  = 8'h46;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_DATA  = 8'h00;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      tests++;
      if (bus.RSP_VALID !== 1'b0 || bus.BUSY !== 1'b1) begin
         fails++;
         $display("FAIL alu_done got v=%b busy=%b req 0/1",
                  bus.RSP_VALID, bus.BUSY);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h0046) begin
         fails++;
         $display("FAIL alu_rsp got v=%b d=%h req 1/0046",
                  bus.RSP_VALID, bus.RSP_DATA);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      logic [7:0] exp [4];
      logic [7:0] got [4];
      int cyc;
      bit held;
      exp = '{8'hDD, 8'h00, 8'h00, 8'h00};
      issue(2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
      run_frame(2, 1'b0, got, cyc, held);
      for (int j = 0; j < 2; j++) begin
         tests++;
         if (got[j] !== exp[j]) begin
            fails++;
            $display("FAIL to_tx[%0d] got %h req %h", j, got[j], exp[j]);
         end
      end
      bus.RX_DATA  = 8'h55;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
      for (int j = 1; j <= 16; j++) begin
         tests++;
         if (bus.RSP_TIMEOUT !== 1'b0 || bus.BUSY !== 1'b1 ||
             bus.RSP_VALID !== 1'b0) begin
            fails++;
            $display("FAIL to_wait[%0d] got to=%b busy=%b v=%b req 0/1/0",
                     j, bus.RSP_TIMEOUT, bus.BUSY, bus.RSP_VALID);
         end
         @(negedge clk);
      end
      tests++;
      if (bus.RSP_TIMEOUT !== 1'b1 || bus.RSP_VALID !== 1'b0 ||
          bus.CMD_READY !== 1'b1 || bus.RSP_DATA !== 16'h0046) begin
         fails++;
         $display("FAIL to_pulse got to=%b v=%b rdy=%b d=%h req 1/0/1/0046",
                  bus.RSP_TIMEOUT, bus.RSP_VALID, bus.CMD_READY, bus.RSP_DATA);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_TIMEOUT !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
         fails++;
         $display("FAIL to_after got to=%b v=%b req 0/0",
                  bus.RSP_TIMEOUT, bus.RSP_VALID);
      end
`else
      for (int j = 1; j <= 20; j++) begin
         tests++;
         if (bus.RSP_TIMEOUT !== 1'b0 || bus.BUSY !== 1'b1) begin
            fails++;
            $display("FAIL to_wait[%0d] got to=%b busy=%b req 0/1",
                     j, bus.RSP_TIMEOUT, bus.BUSY);
         end
         @(negedge clk);
      end
      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h0055) begin
         fails++;
         $display("FAIL to_late_rsp got v=%b d=%h req 1/0055",
                  bus.RSP_VALID, bus.RSP_DATA);
      end
      @(negedge clk);
`endif
   endtask

   task automatic test_terminal;
      issue(2'b01, 8'h21, 8'h00, 8'h00, 8'h00, 4'h0);
      bus.TX_READY  = 1'b0;
      bus.CMD_VALID = 1'b1;
      bus.CMD_TYPE  = 2'b00;
      bus.CMD_ADDR  = 8'h77;
      @(negedge clk);
      tests++;
      if (bus.CMD_READY !== 1'b0 || bus.TX_VALID !== 1'b1 ||
          bus.TX_DATA !== 8'hBB) begin
         fails++;
         $display("FAIL term_stall got rdy=%b v=%b d=%h req 0/1/bb",
                  bus.CMD_READY, bus.TX_VALID, bus.TX_DATA);
      end
      bus.CMD_VALID = 1'b0;
      bus.TX_READY  = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'h21) begin
         fails++;
         $display("FAIL term_addr got v=%b d=%h req 1/21",
                  bus.TX_VALID, bus.TX_DATA);
      end
      @(negedge clk);
      repeat (15) @(negedge clk);
      bus.RX_DATA  = 8'hA5;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      tests++;
      if (bus.RSP_TIMEOUT !== 1'b0 || bus.BUSY !== 1'b1) begin
         fails++;
         $display("FAIL term_no_to got to=%b busy=%b req 0/1",
                  bus.RSP_TIMEOUT, bus.BUSY);
      end
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h00A5 ||
          bus.RSP_TIMEOUT !== 1'b0) begin
         fails++;
         $display("FAIL term_rsp got v=%b d=%h to=%b req 1/00a5/0",
                  bus.RSP_VALID, bus.RSP_DATA, bus.RSP_TIMEOUT);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp [4];
      logic [7:0] got [4];
      int cyc;
      bit held;
      bus.TX_READY = 1'b1;
      issue(2'b10, 8'h00, 8'h00, 8'h11, 8'h22, 4'h3);
      @(negedge clk);
      tests++;
      if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'h11) begin
         fails++;
         $display("FAIL rmid_byte1 got v=%b d=%h req 1/11",
                  bus.TX_VALID, bus.TX_DATA);
      end
      bus.TX_READY = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (bus.TX_VALID !== 1'b0 || bus.BUSY !== 1'b0 ||
          bus.CMD_READY !== 1'b1) begin
         fails++;
         $display("FAIL rmid_abort got v=%b busy=%b rdy=%b req 0/0/1",
                  bus.TX_VALID, bus.BUSY, bus.CMD_READY);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.TX_READY = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tests++;
         if (bus.RSP_VALID !== 1'b0 || bus.RSP_TIMEOUT !== 1'b0 ||
             bus.TX_VALID !== 1'b0) begin
            fails++;
            $display("FAIL rmid_quiet[%0d] got v=%b to=%b tv=%b req 0/0/0",
                     j, bus.RSP_VALID, bus.RSP_TIMEOUT, bus.TX_VALID);
         end
         @(negedge clk);
      end
      exp = '{8'hBB, 8'h09, 8'h00, 8'h00};
      issue(2'b01, 8'h09, 8'h00, 8'h00, 8'h00, 4'h0);
      run_frame(2, 1'b0, got, cyc, held);
      for (int j = 0; j < 2; j++) begin
         tests++;
         if (got[j] !== exp[j]) begin
            fails++;
            $display("FAIL rmid_tx[%0d] got %h req %h", j, got[j], exp[j]);
         end
      end
      bus.RX_DATA  = 8'hC3;
      bus.RX_VALID = 1'b1;
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 16'h00C3) begin
         fails++;
         $display("FAIL rmid_rsp got v=%b d=%h req 1/00c3",
                  bus.RSP_VALID, bus.RSP_DATA);
      end
      @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.CMD_VALID = 1'b0;
      bus.CMD_TYPE  = 2'b00;
      bus.CMD_ADDR  = 8'h00;
      bus.CMD_DATA  = 8'h00;
      bus.CMD_OP_A  = 8'h00;
      bus.CMD_OP_B  = 8'h00;
      bus.CMD_FUN   = 4'h0;
      bus.TX_READY  = 1'b1;
      bus.RX_DATA   = 8'h00;
      bus.RX_VALID  = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_alu();
      test_timeout();
      test_terminal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
